// File: rtl/instr_encoder.sv
// Purpose: packs RV32I field bundles into instruction words and tags each word with its byte address.
// Latency: 1 cycle from accepted bundle to out_valid; sustains one word per cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output word holds every out_* stable.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP = 32'd4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        restart,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic [15:0] err_count
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_err_q,   out_err_d;
   logic [31:0] out_addr_q,  out_addr_d;
   logic [31:0] next_addr_q, next_addr_d;
   logic [15:0] err_count_q, err_count_d;

   logic [31:0] enc_raw;
   logic        enc_bad;
   logic        accept;
   logic        xfer;
   logic        fits12;
   logic        fits13;
   logic        fits21;
   logic        is_shift;

   // An immediate fits N signed bits when everything above bit N-2 is a copy of the sign.
   assign fits12   = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign fits13   = (&in_imm[31:12]) || !(|in_imm[31:12]);
   assign fits21   = (&in_imm[31:20]) || !(|in_imm[31:20]);
   // SLLI/SRLI/SRAI carry funct7 above a 5-bit shift amount instead of a 12-bit immediate.
   assign is_shift = (in_funct3[1:0] == 2'b01);

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid_q && out_ready;

   // Scatter the fields into the format selected by opcode and flag anything unencodable.
   always_comb begin
      enc_raw = 32'h0;
      enc_bad = 1'b0;
      case (in_opcode)
         OP_R: begin
            enc_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         end
         OP_IMM: begin
            if (is_shift) begin
               enc_raw = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
               enc_bad = |in_imm[31:5];
            end else begin
               enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
               enc_bad = !fits12;
            end
         end
         OP_LOAD, OP_JALR: begin
            enc_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            enc_bad = !fits12;
         end
         OP_STORE: begin
            enc_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_bad = !fits12;
         end
         OP_BRANCH: begin
            enc_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
            enc_bad = in_imm[0] || !fits13;
         end
         OP_JAL: begin
            enc_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_bad = in_imm[0] || !fits21;
         end
         OP_LUI, OP_AUIPC: begin
            enc_raw = {in_imm[31:12], in_rd, in_opcode};
            enc_bad = |in_imm[11:0];
         end
         default: begin
            enc_bad = 1'b1;
         end
      endcase
   end

   // Output stage, address allocation and error counter; restart overrides a concurrent transfer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_err_d   = out_err_q;
      out_addr_d  = out_addr_q;
      next_addr_d = next_addr_q;
      err_count_d = err_count_q;

      if (xfer) begin
         out_valid_d = 1'b0;
      end
      // Addresses are handed out at accept time; every accepted word is eventually
      // transferred (barring reset), so this matches counting transfers.
      if (accept) begin
         out_valid_d = 1'b1;
         out_instr_d = enc_bad ? 32'h0 : enc_raw;
         out_err_d   = enc_bad;
         out_addr_d  = restart ? BASE_ADDR : next_addr_q;
      end

      if (restart) begin
         next_addr_d = accept ? (BASE_ADDR + ADDR_STEP) : BASE_ADDR;
      end else if (accept) begin
         next_addr_d = next_addr_q + ADDR_STEP;
      end

      if (restart) begin
         err_count_d = 16'h0;
      end else if (xfer && out_err_q && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   // State registers with synchronous reset; a held word is simply dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         out_err_q   <= 1'b0;
         out_addr_q  <= BASE_ADDR;
         next_addr_q <= BASE_ADDR;
         err_count_q <= 16'h0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_err_q   <= out_err_d;
         out_addr_q  <= out_addr_d;
         next_addr_q <= next_addr_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign out_addr  = out_addr_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus randomized bundles against a behavioural model.
// Expected words are queued on accept; a negedge monitor compares whatever the DUT presents.
// Random output backpressure, restart pulses and a mid-stream reset are exercised.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] STEP = 32'd4;

   logic        clock;
   logic        reset;
   logic        restart;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic [15:0] err_count;

   instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
      .clock(clock), .reset(reset), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic [31:0] addr;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [1:0]  gmask;   // bit0: golden instr/err given, bit1: golden address given
      logic [31:0] ginstr;
      logic        gerr;
      logic [31:0] gaddr;
   } item_t;

   item_t       sb[$];
   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] next_addr = BASE;
   int          err_model = 0;
   bit          post_reset = 0;
   bit          stall = 0;
   bit          full_rdy = 1;
   logic [1:0]  gold_mask = 2'b00;
   logic [31:0] gold_instr = 32'h0;
   logic        gold_err = 1'b0;
   logic [31:0] gold_addr = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic logic [31:0] put(input logic [31:0] v, input int pos);
      return v << pos;
   endfunction

   function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
      return (v >> lo) & ((32'd1 << n) - 32'd1);
   endfunction

   function automatic bit fits(input logic [31:0] v, input int n);
      int s;
      s = $signed(v);
      return (s >= -(1 << (n - 1))) && (s < (1 << (n - 1)));
   endfunction

   function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm,
                                      output logic [31:0] w, output logic e);
      logic [31:0] common;
      common = put(32'(op), 0) | put(32'(f3), 12) | put(32'(rs1), 15);
      w = 32'h0;
      e = 1'b0;
      case (op)
         7'b0110011: w = common | put(32'(rd), 7) | put(32'(rs2), 20) | put(32'(f7), 25);
         7'b0010011, 7'b0000011, 7'b1100111: begin
            if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
               e = (imm > 32'd31);
               w = common | put(32'(rd), 7) | put(bits(imm, 0, 5), 20) | put(32'(f7), 25);
            end else begin
               e = !fits(imm, 12);
               w = common | put(32'(rd), 7) | put(bits(imm, 0, 12), 20);
            end
         end
         7'b0100011: begin
            e = !fits(imm, 12);
            w = common | put(bits(imm, 0, 5), 7) | put(32'(rs2), 20) | put(bits(imm, 5, 7), 25);
         end
         7'b1100011: begin
            e = ((imm % 2) != 0) || !fits(imm, 13);
            w = common | put(bits(imm, 11, 1), 7) | put(bits(imm, 1, 4), 8) | put(32'(rs2), 20)
                | put(bits(imm, 5, 6), 25) | put(bits(imm, 12, 1), 31);
         end
         7'b1101111: begin
            e = ((imm % 2) != 0) || !fits(imm, 21);
            w = put(32'(op), 0) | put(32'(rd), 7) | put(bits(imm, 12, 8), 12)
                | put(bits(imm, 11, 1), 20) | put(bits(imm, 1, 10), 21) | put(bits(imm, 20, 1), 31);
         end
         7'b0110111, 7'b0010111: begin
            e = (imm % 4096) != 0;
            w = put(32'(op), 0) | put(32'(rd), 7) | (imm - (imm % 4096));
         end
         default: e = 1'b1;
      endcase
      if (e) w = 32'h0;
   endfunction

   // Decoder-side immediate extraction, used to confirm encoded words round-trip.
   function automatic logic [31:0] dec_imm(input logic [31:0] w, input int fmt);
      case (fmt)
         0: return {{20{w[31]}}, w[31:20]};
         1: return {{20{w[31]}}, w[31:25], w[11:7]};
         2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         3: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return {w[31:12], 12'h0};
      endcase
   endfunction

   function automatic int imm_fmt(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? -1 : 0;
         7'b0000011, 7'b1100111: return 0;
         7'b0100011: return 1;
         7'b1100011: return 2;
         7'b1101111: return 3;
         7'b0110111, 7'b0010111: return 4;
         default: return -1;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      item_t it;
      item_t nw;
      int    fmt;
      if (post_reset) begin
         chk("reset_out_valid", 32'(out_valid), 32'd0);
         chk("reset_out_instr", out_instr, 32'd0);
         chk("reset_out_err", 32'(out_err), 32'd0);
         chk("reset_out_addr", out_addr, BASE);
         chk("reset_err_count", 32'(err_count), 32'd0);
         chk("reset_in_ready", 32'(in_ready), 32'd1);
         post_reset = 0;
      end
      chk("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("err_count", 32'(err_count), 32'(err_model));
      if (out_valid && sb.size() > 0) begin
         it = sb[0];
         chk("out_instr", out_instr, it.instr);
         chk("out_err", 32'(out_err), 32'(it.err));
         chk("out_addr", out_addr, it.addr);
      end
      if (reset) begin
         sb.delete();
         next_addr  = BASE;
         err_model  = 0;
         post_reset = 1;
      end else begin
         if (out_valid && out_ready && sb.size() > 0) begin
            it = sb.pop_front();
            if (it.gmask[0]) begin
               chk("golden_instr", out_instr, it.ginstr);
               chk("golden_err", 32'(out_err), 32'(it.gerr));
            end
            if (it.gmask[1]) chk("golden_addr", out_addr, it.gaddr);
            fmt = imm_fmt(it.op, it.f3);
            if (!it.err && fmt >= 0) chk("roundtrip_imm", dec_imm(out_instr, fmt), it.imm);
            if (it.err && err_model < 65535) err_model++;
         end
         if (restart) begin
            err_model = 0;
            next_addr = BASE;
         end
         if (in_valid && in_ready) begin
            ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
                       nw.instr, nw.err);
            nw.addr   = next_addr;
            nw.op     = in_opcode;
            nw.f3     = in_funct3;
            nw.imm    = in_imm;
            nw.gmask  = gold_mask;
            nw.ginstr = gold_instr;
            nw.gerr   = gold_err;
            nw.gaddr  = gold_addr;
            sb.push_back(nw);
            next_addr = next_addr + STEP;
         end
      end
   end

   // Downstream readiness: forced low while stalled, forced high for directed work, else random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (stall) out_ready = 1'b0;
         else if (full_rdy) out_ready = 1'b1;
         else out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic set_gold(input logic [1:0] m, input logic [31:0] gi, input logic ge,
                           input logic [31:0] ga);
      gold_mask = m; gold_instr = gi; gold_err = ge; gold_addr = ga;
   endtask

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic rs);
      int waited;
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid  = 1'b1;
      restart   = rs;
      waited    = 0;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            n_total++;
            $display("FAIL drive_timeout: in_ready stayed %0b for %0d cycles", in_ready, waited);
            break;
         end
         @(posedge clock);
         #1;
         restart = 1'b0;
      end
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      restart   = 1'b0;
      gold_mask = 2'b00;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         @(posedge clock);
         #2;
         if (sb.size() == 0 && !out_valid) return;
      end
      n_total++;
      $display("FAIL drain_timeout: %0d words still queued", sb.size());
   endtask

   function automatic logic [31:0] rand_imm();
      int v;
      case ($urandom_range(0, 6))
         0: v = int'($urandom_range(0, 40));
         1: v = int'($urandom_range(0, 127)) - 64;
         2: v = int'($urandom_range(0, 8191)) - 4096;
         3: v = int'($urandom_range(0, 16383)) - 8192;
         4: v = int'($urandom_range(0, 4194303)) - 2097152;
         5: v = int'(($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) == 0));
         default: v = int'($urandom);
      endcase
      return 32'(v);
   endfunction

   logic [6:0]  ops [0:8];
   logic [6:0]  bop [0:7];
   logic [31:0] bimm [0:7];

   initial begin
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
      // Range edges: last encodable value and first value past it, for I, B and J.
      bop  = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
               7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111};
      bimm = '{32'd2047, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd2048,
               32'd4094, 32'd4096, 32'h000F_FFFE, 32'h0010_0000};

      reset = 1'b1; restart = 1'b0; in_valid = 1'b0;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Directed encodings with known words and addresses.
      set_gold(2'b11, 32'hFFF0_0093, 1'b0, BASE);
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b0);
      set_gold(2'b11, 32'hFE51_2C23, 1'b0, BASE + 32'd4);
      drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'hFFFF_FFF8, 1'b0);
      set_gold(2'b01, 32'hFE20_8EE3, 1'b0, 32'h0);
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 1'b0);
      set_gold(2'b01, 32'h0010_00EF, 1'b0, 32'h0);
      drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0);

      // Four unencodable bundles.
      set_gold(2'b01, 32'h0, 1'b1, 32'h0);
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0);
      set_gold(2'b01, 32'h0, 1'b1, 32'h0);
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 1'b0);
      set_gold(2'b01, 32'h0, 1'b1, 32'h0);
      drive(7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_1001, 1'b0);
      set_gold(2'b01, 32'h0, 1'b1, 32'h0);
      drive(7'b0010011, 5'd4, 5'd5, 5'd0, 3'b101, 7'b0100000, 32'd32, 1'b0);
      wait_drain();
      chk("err_count_after_four", 32'(err_count), 32'd4);

      for (int i = 0; i < 8; i++) drive(bop[i], 5'd7, 5'd8, 5'd9, 3'b000, 7'd0, bimm[i], 1'b0);
      wait_drain();

      // Restart coinciding with a transfer.
      drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0);
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd1, 1'b0);
      drive(7'b0010011, 5'd2, 5'd2, 5'd0, 3'b000, 7'd0, 32'd7, 1'b0);
      restart = 1'b1;
      @(posedge clock);
      #1;
      restart = 1'b0;
      chk("restart_err_count", 32'(err_count), 32'd0);
      set_gold(2'b10, 32'h0, 1'b0, BASE);
      drive(7'b0110011, 5'd3, 5'd4, 5'd5, 3'b000, 7'b0100000, 32'd0, 1'b0);
      wait_drain();

      // Backpressure: one word held, the next two wait, then all drain in order.
      stall = 1;
      @(posedge clock);
      #2;
      drive(7'b0010011, 5'd10, 5'd0, 5'd0, 3'b000, 7'd0, 32'd10, 1'b0);
      fork
         begin
            repeat (5) @(posedge clock);
            stall = 0;
         end
      join_none
      drive(7'b0010011, 5'd11, 5'd0, 5'd0, 3'b000, 7'd0, 32'd11, 1'b0);
      drive(7'b0010011, 5'd12, 5'd0, 5'd0, 3'b000, 7'd0, 32'd12, 1'b0);
      wait_drain();

      // Randomized bundles, random readiness and occasional restarts.
      full_rdy = 0;
      for (int k = 0; k < 400; k++) begin
         int sel;
         logic [6:0] op;
         sel = int'($urandom_range(0, 9));
         op  = (sel == 9) ? 7'($urandom) : ops[sel];
         drive(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
               rand_imm(), $urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
         end
      end
      full_rdy = 1;
      wait_drain();

      // Reset while a word is held.
      stall = 1;
      @(posedge clock);
      #2;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd99, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      stall = 0;
      chk("reset_drops_word", 32'(out_valid), 32'd0);
      set_gold(2'b10, 32'h0, 1'b0, BASE);
      drive(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b0);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
